// File: rtl/spi_sram_wb_ctrl.sv
// Wishbone classic slave that maps each 32-bit access onto one SPI serial-SRAM transaction (SPI mode 0).
// Optional build macro SPI_SRAM_FASTREAD_EN: reads use FAST READ (0x0B) followed by 8 dummy clocks.
module spi_sram_wb_ctrl #(
  parameter int CLK_DIV   = 1,
  parameter int ADDR_BITS = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        spi_cs_n_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        busy_o
);
  // Outgoing bit stream: command, address, write bytes (or zeros), 8 spare zero bits for the dummy phase.
  localparam int SH_W = 8 + ADDR_BITS + 40;
`ifdef SPI_SRAM_FASTREAD_EN
  localparam logic [7:0] RD_CMD = 8'h0B;
`else
  localparam logic [7:0] RD_CMD = 8'h03;
`endif
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [SH_W-1:0] sh_q, sh_d;
  logic [31:0]     rx_q, rx_d, dat_o_q, dat_o_d;
  logic [15:0]     div_q, div_d;
  logic [7:0]      bit_q, bit_d;
  logic [5:0]      data_bits_q, data_bits_d;
  logic            we_q, we_d, sclk_q, sclk_d;

  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic [31:0] wr_shift, wr_stream;
  logic [7:0]  cur_len;
  logic        spi_active;
  logic        unused_adr_bits;

  assign unused_adr_bits = ^{wb_adr_i[1:0], wb_adr_i[31:ADDR_BITS]};

  always_comb begin
    off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (wb_sel_i[i]) off = 2'(i);
    end
  end

  assign nbytes    = 3'(wb_sel_i[0]) + 3'(wb_sel_i[1]) + 3'(wb_sel_i[2]) + 3'(wb_sel_i[3]);
  // Lowest enabled lane goes out first, each byte MSB first.
  assign wr_shift  = wb_dat_i >> {off, 3'b000};
  assign wr_stream = {wr_shift[7:0], wr_shift[15:8], wr_shift[23:16], wr_shift[31:24]};

  always_comb begin
    case (state_q)
      S_CMD, S_DUMMY: cur_len = 8'd8;
      S_ADDR:         cur_len = 8'(ADDR_BITS);
      default:        cur_len = {2'b00, data_bits_q};
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      rx_q        <= '0;
      dat_o_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      data_bits_q <= '0;
      we_q        <= 1'b0;
      sclk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      dat_o_q     <= dat_o_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      data_bits_q <= data_bits_d;
      we_q        <= we_d;
      sclk_q      <= sclk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    dat_o_d     = dat_o_q;
    div_d       = div_q;
    bit_d       = bit_q;
    data_bits_d = data_bits_q;
    we_d        = we_q;
    sclk_d      = sclk_q;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          we_d        = wb_we_i;
          div_d       = '0;
          bit_d       = '0;
          sclk_d      = 1'b0;
          data_bits_d = wb_we_i ? {nbytes, 3'b000} : 6'd32;
          sh_d        = {(wb_we_i ? 8'h02 : RD_CMD), wb_adr_i[ADDR_BITS-1:2],
                         (wb_we_i ? off : 2'b00), (wb_we_i ? wr_stream : 32'h0), 8'h00};
          state_d     = (wb_we_i && wb_sel_i == 4'b0000) ? S_DONE : S_CMD;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (!wb_cyc_i) begin
          state_d = S_GAP;
          sclk_d  = 1'b0;
          div_d   = '0;
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + 16'd1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising SCLK edge: sample MISO only while receiving read data.
            sclk_d = 1'b1;
            if (state_q == S_DATA && !we_q) rx_d = {rx_q[30:0], spi_miso_i};
          end else begin
            sclk_d = 1'b0;
            sh_d   = sh_q << 1;
            if (bit_q != cur_len - 8'd1) begin
              bit_d = bit_q + 8'd1;
            end else begin
              bit_d = '0;
              case (state_q)
                S_CMD:   state_d = S_ADDR;
`ifdef SPI_SRAM_FASTREAD_EN
                S_ADDR:  state_d = we_q ? S_DATA : S_DUMMY;
`else
                S_ADDR:  state_d = S_DATA;
`endif
                S_DUMMY: state_d = S_DATA;
                default: begin
                  state_d = S_DONE;
                  if (!we_q) dat_o_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                end
              endcase
            end
          end
        end
      end
      S_DONE:  state_d = S_GAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    spi_active = (state_q == S_CMD) || (state_q == S_ADDR) ||
                 (state_q == S_DUMMY) || (state_q == S_DATA);
    spi_cs_n_o = !spi_active;
    spi_sclk_o = sclk_q;
    spi_mosi_o = spi_active & sh_q[SH_W-1];
    wb_ack_o   = (state_q == S_DONE);
    busy_o     = (state_q != S_IDLE);
    wb_dat_o   = dat_o_q;
  end

endmodule

// File: tb/tb_spi_sram_wb_ctrl.sv
// Bench for spi_sram_wb_ctrl: two instances (CLK_DIV 1 and 3), each attached to a behavioural SPI SRAM,
// checked against a byte-array reference memory and the transaction timing rules.
module tb_spi_sram_wb_ctrl;
`ifdef SPI_SRAM_FASTREAD_EN
  localparam int         RD_BITS = 72;
  localparam int         PRE     = 40;
  localparam logic [7:0] RD_CMD  = 8'h0B;
`else
  localparam int         RD_BITS = 64;
  localparam int         PRE     = 32;
  localparam logic [7:0] RD_CMD  = 8'h03;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr [2];
  logic [31:0] dat_w [2];
  logic [31:0] dat_r [2];
  logic [3:0]  sel [2];
  logic        we [2], stb [2], cyc [2], ack [2], cs_n [2], sclk [2], mosi [2], busy [2];

  int checks = 0;
  int failures = 0;
  logic [7:0]  ref_mem [2][8192];
  logic [31:0] last_rd [2];

  function automatic logic [7:0] init_byte(input int k, input int a);
    case (a)
      'h1234:  return 8'hEF;
      'h1235:  return 8'hBE;
      'h1236:  return 8'hAD;
      'h1237:  return 8'hDE;
      default: return 8'((a * 37) ^ (a >> 5) ^ (k * 91));
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int DIV = (gi == 0) ? 1 : 3;
      logic        miso_l = 1'b0;
      logic [7:0]  mem [8192];
      logic [7:0]  cmd_c = 8'h00;
      logic [23:0] addr_c = 24'h0;
      logic [7:0]  byte_c = 8'h00;
      int          bitn = 0;
      int          nbytes_c = 0;
      int          dd = 0;
      int          stab_err = 0;
      int          min_gap = 1000;
      int          hi_cnt = 0;
      logic        sclk_prev = 1'b0;
      logic        mosi_prev = 1'b0;

      spi_sram_wb_ctrl #(.CLK_DIV(DIV), .ADDR_BITS(24)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_adr_i(adr[gi]), .wb_dat_i(dat_w[gi]), .wb_sel_i(sel[gi]),
        .wb_we_i(we[gi]), .wb_stb_i(stb[gi]), .wb_cyc_i(cyc[gi]),
        .wb_dat_o(dat_r[gi]), .wb_ack_o(ack[gi]),
        .spi_cs_n_o(cs_n[gi]), .spi_sclk_o(sclk[gi]), .spi_mosi_o(mosi[gi]),
        .spi_miso_i(miso_l), .busy_o(busy[gi])
      );

      initial begin
        for (int i = 0; i < 8192; i++) mem[i] = init_byte(gi, i);
      end

      // SPI SRAM slave: decode command, address and write bytes from MOSI on rising SCLK.
      always @(posedge sclk[gi] or posedge cs_n[gi]) begin
        if (cs_n[gi]) begin
          bitn = 0;
        end else begin
          if (bitn == 0) nbytes_c = 0;
          if (bitn < 8) cmd_c = {cmd_c[6:0], mosi[gi]};
          else if (bitn < 32) addr_c = {addr_c[22:0], mosi[gi]};
          else if (cmd_c == 8'h02) begin
            byte_c = {byte_c[6:0], mosi[gi]};
            if (bitn % 8 == 7) begin
              mem[13'(addr_c + 24'(nbytes_c))] = byte_c;
              nbytes_c++;
            end
          end
          bitn++;
        end
      end

      // Read data shifted out on falling SCLK; junk during command, address and dummy phases.
      always @(negedge sclk[gi]) begin
        if (cmd_c == RD_CMD && bitn >= PRE) begin
          dd = bitn - PRE;
          miso_l = mem[13'(addr_c + 24'(dd / 8))][7 - (dd % 8)];
        end else begin
          miso_l = 1'($urandom);
        end
      end

      always @(negedge clk) begin
        if (sclk[gi] && sclk_prev && (mosi[gi] !== mosi_prev)) stab_err++;
        if (cs_n[gi]) hi_cnt++;
        else begin
          if (hi_cnt > 0 && hi_cnt < min_gap) min_gap = hi_cnt;
          hi_cnt = 0;
        end
        sclk_prev = sclk[gi];
        mosi_prev = mosi[gi];
      end
    end
  endgenerate

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_cap(input int k, output logic [7:0] c, output logic [23:0] a, output int n);
    if (k == 0) begin
      c = g_dut[0].cmd_c; a = g_dut[0].addr_c; n = g_dut[0].nbytes_c;
    end else begin
      c = g_dut[1].cmd_c; a = g_dut[1].addr_c; n = g_dut[1].nbytes_c;
    end
  endtask

  // mode 0: normal, 1: drop cyc at cycle stop_at, 2: assert reset at cycle stop_at.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int mode, input int stop_at);
    int div, nb, lo, exp_cyc, ncyc, cn;
    logic got, acc, pb;
    logic [7:0] cc;
    logic [23:0] ca;
    logic [12:0] wa;
    logic [31:0] exp_rd;
    div = (k == 0) ? 1 : 3;
    nb  = $countones(s);
    lo  = 0;
    for (int i = 3; i >= 0; i--) if (s[i]) lo = i;
    exp_cyc = (w && s == 4'b0000) ? 1 : 1 + 2 * div * (w ? 32 + 8 * nb : RD_BITS);
    wa = {a[12:2], 2'b00};
    exp_rd = {ref_mem[k][wa + 13'd3], ref_mem[k][wa + 13'd2], ref_mem[k][wa + 13'd1], ref_mem[k][wa]};
    @(negedge clk);
    adr[k] = a; dat_w[k] = d; sel[k] = s; we[k] = w; cyc[k] = 1'b1; stb[k] = 1'b1;
    pb = busy[k]; acc = 1'b0; got = 1'b0; ncyc = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (acc) ncyc++;
      else if (busy[k] && !pb) begin acc = 1'b1; ncyc = 1; end
      pb = busy[k];
      if (ack[k]) got = 1'b1;
      if (mode == 0) begin
        if (got) break;
      end else if (acc && ncyc == stop_at) begin
        if (mode == 1) begin
          cyc[k] = 1'b0; stb[k] = 1'b0;
        end else begin
          #2 rst = 1'b1;
          #1;
          chk($sformatf("rst_cs_n%0d", k), 64'(cs_n[k]), 64'd1);
          chk($sformatf("rst_sclk%0d", k), 64'(sclk[k]), 64'd0);
          chk($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
          @(negedge clk); @(negedge clk);
          rst = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
          last_rd[0] = '0; last_rd[1] = '0;
          break;
        end
      end else if (mode == 1 && acc && ncyc == stop_at + 1) begin
        chk($sformatf("abort_cs_n%0d", k), 64'(cs_n[k]), 64'd1);
        chk($sformatf("abort_sclk%0d", k), 64'(sclk[k]), 64'd0);
      end else if (mode == 1 && acc && ncyc >= stop_at + 40) begin
        break;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    $display("txn inst=%0d mode=%0d we=%0b adr=%h sel=%b dat=%h ack=%0b cycle=%0d dat_o=%h",
             k, mode, w, a, s, d, got, ncyc, dat_r[k]);
    if (mode == 0) begin
      chk($sformatf("ack_seen%0d", k), 64'(got), 64'd1);
      chk($sformatf("ack_cycle%0d", k), 64'(ncyc), 64'(exp_cyc));
      get_cap(k, cc, ca, cn);
      if (!w) begin
        chk($sformatf("rd_cmd%0d", k), 64'(cc), 64'(RD_CMD));
        chk($sformatf("rd_addr%0d", k), 64'(ca), 64'({a[23:2], 2'b00}));
        chk($sformatf("rd_data%0d", k), 64'(dat_r[k]), 64'(exp_rd));
        last_rd[k] = exp_rd;
      end else begin
        chk($sformatf("wr_dat_hold%0d", k), 64'(dat_r[k]), 64'(last_rd[k]));
        if (s != 4'b0000) begin
          chk($sformatf("wr_cmd%0d", k), 64'(cc), 64'h02);
          chk($sformatf("wr_addr%0d", k), 64'(ca), 64'({a[23:2], 2'(lo)}));
          chk($sformatf("wr_nbytes%0d", k), 64'(cn), 64'(nb));
        end
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[k][wa + 13'(i)] = d[8*i +: 8];
      end
    end else if (mode == 1) begin
      chk($sformatf("abort_accepted%0d", k), 64'(acc), 64'd1);
      chk($sformatf("abort_no_ack%0d", k), 64'(got), 64'd0);
      chk($sformatf("abort_dat_hold%0d", k), 64'(dat_r[k]), 64'(last_rd[k]));
    end else begin
      chk($sformatf("rst_dat_o%0d", k), 64'(dat_r[k]), 64'd0);
    end
  endtask

  initial begin
    logic [3:0] sel_tab [11];
    int k;
    sel_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110,
                4'b1100, 4'b0111, 4'b1110, 4'b1111, 4'b0000};
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 8192; a++) ref_mem[m][a] = init_byte(m, a);
      adr[m] = '0; dat_w[m] = '0; sel[m] = '0; we[m] = 1'b0;
      cyc[m] = 1'b0; stb[m] = 1'b0; last_rd[m] = '0;
    end
    #1 rst = 1'b1;
    #2;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset_cs_n%0d", m), 64'(cs_n[m]), 64'd1);
      chk($sformatf("reset_sclk%0d", m), 64'(sclk[m]), 64'd0);
      chk($sformatf("reset_mosi%0d", m), 64'(mosi[m]), 64'd0);
      chk($sformatf("reset_ack%0d", m), 64'(ack[m]), 64'd0);
      chk($sformatf("reset_dat%0d", m), 64'(dat_r[m]), 64'd0);
      chk($sformatf("reset_busy%0d", m), 64'(busy[m]), 64'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    txn(0, 1'b0, 32'h0000_1234, 32'h0, 4'hF, 0, 0);
    txn(0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b1100, 0, 0);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 0);
    txn(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0000, 0, 0);
    txn(1, 1'b0, 32'h0000_1234, 32'h0, 4'hF, 0, 0);
    txn(1, 1'b1, 32'hFF00_0105, 32'h89AB_CDEF, 4'b0111, 0, 0);
    txn(1, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 0, 0);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 20);
    txn(0, 1'b0, 32'h0000_1234, 32'h0, 4'hF, 0, 0);

    for (int it = 0; it < 28; it++) begin
      k = (it % 4 == 3) ? 1 : 0;
      txn(k, 1'($urandom), {8'($urandom), 11'h0, 13'($urandom)}, $urandom,
          sel_tab[$urandom_range(0, 10)], 0, 0);
      if (it % 3 == 0)
        txn(k, 1'b0, {8'($urandom), 11'h0, 13'($urandom)}, 32'h0, 4'hF, 0, 0);
    end

    txn(0, 1'b1, 32'h0000_0044, 32'h5566_7788, 4'b0011, 2, 20);
    txn(0, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 0, 0);
    txn(0, 1'b0, 32'h0000_1234, 32'h0, 4'hF, 0, 0);

    chk("cs_gap0", 64'(g_dut[0].min_gap >= 2), 64'd1);
    chk("cs_gap1", 64'(g_dut[1].min_gap >= 2), 64'd1);
    chk("mosi_stable_hi0", 64'(g_dut[0].stab_err), 64'd0);
    chk("mosi_stable_hi1", 64'(g_dut[1].stab_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
